// File: rtl/logic_ops_pkg.sv
// Shared definitions for the bitwise logic-op unit.
//   - 3-bit operation codes used on the op port and inside the slice unit
//   - FSM state encoding for the sequencing top level
package logic_ops_pkg;

    localparam logic [2:0] OP_NOT  = 3'd0;  // ~A
    localparam logic [2:0] OP_AND  = 3'd1;  //  A & B
    localparam logic [2:0] OP_OR   = 3'd2;  //  A | B
    localparam logic [2:0] OP_XOR  = 3'd3;  //  A ^ B
    localparam logic [2:0] OP_NAND = 3'd4;  // ~(A & B)
    localparam logic [2:0] OP_NOR  = 3'd5;  // ~(A | B)
    localparam logic [2:0] OP_XNOR = 3'd6;  // ~(A ^ B)
    localparam logic [2:0] OP_PASS = 3'd7;  //  A

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bitwise_slice.sv
// Combinational SLICE-wide bitwise operation unit.
// Ports:
//   op : operation code (see logic_ops_pkg)
//   a  : operand A slice
//   b  : operand B slice (ignored by NOT / PASS)
//   y  : result slice
module bitwise_slice
    import logic_ops_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [2:0]       op,
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic [SLICE-1:0] y
);

    always_comb begin
        y = a;
        case (op)
            OP_NOT:  y = ~a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            OP_PASS: y = a;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/bitwise_logic_seq.sv
// Multi-cycle bitwise logic-op unit. Applies one of eight bitwise operations
// to WIDTH-bit operands, SLICE bits per clock, LSB slice first.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high reset (overrides start)
//   start  : request, sampled only in IDLE
//   op     : operation code, latched with start
//   a, b   : operands, latched with start
//   busy   : high while slices are being computed (NSLICE cycles)
//   done   : one-cycle pulse once the full result is written
//   result : registered result, held until the next accepted start
//   zero   : result == 0
module bitwise_logic_seq
    import logic_ops_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [2:0]       op_lat;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] y_sl;

    // Operands come only from the latches, so input changes after the
    // accepting edge cannot disturb the operation in flight.
    assign a_sl = a_lat[idx*SLICE +: SLICE];
    assign b_sl = b_lat[idx*SLICE +: SLICE];

    bitwise_slice #(
        .SLICE(SLICE)
    ) u_slice (
        .op(op_lat),
        .a (a_sl),
        .b (b_sl),
        .y (y_sl)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            idx    <= '0;
            op_lat <= '0;
            a_lat  <= '0;
            b_lat  <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_lat <= op;
                        a_lat  <= a;
                        b_lat  <= b;
                        // Cleared so unwritten upper slices read 0 while busy.
                        result <= '0;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    result[idx*SLICE +: SLICE] <= y_sl;
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    // Any start seen here is dropped, not queued.
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign zero = (result == '0);

endmodule

// File: tb/tb_bitwise_logic_seq.sv
// Testbench for bitwise_logic_seq. Unit 0 is the default WIDTH=32/SLICE=8
// configuration; units 1..3 are WIDTH=32 with SLICE=32/16/4.
module tb_bitwise_logic_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        st  [4];
    logic [2:0]  opv [4];
    logic [31:0] av  [4];
    logic [31:0] bv  [4];
    logic        bsy [4];
    logic        dn  [4];
    logic [31:0] res [4];
    logic        zr  [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int SL = (g == 0) ? 8 : (g == 1) ? 32 : (g == 2) ? 16 : 4;
        bitwise_logic_seq #(
            .WIDTH(32),
            .SLICE(SL)
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .start (st[g]),
            .op    (opv[g]),
            .a     (av[g]),
            .b     (bv[g]),
            .busy  (bsy[g]),
            .done  (dn[g]),
            .result(res[g]),
            .zero  (zr[g])
        );
    end

    function automatic int slice_of(input int u);
        case (u)
            0: return 8;
            1: return 32;
            2: return 16;
            default: return 4;
        endcase
    endfunction

    // Whole-word reference: the sliced computation must equal the plain
    // 32-bit bitwise operation.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            3'd0: return ~x;
            3'd1: return x & y;
            3'd2: return x | y;
            3'd3: return x ^ y;
            3'd4: return ~(x & y);
            3'd5: return ~(x | y);
            3'd6: return ~(x ^ y);
            default: return x;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation on unit u, checking busy length, done pulse, result,
    // zero flag and result hold. scramble changes inputs right after the
    // accepting edge.
    task automatic do_op(input int u, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit scramble, input string tag);
        logic [31:0] exp;
        int bc;
        int n;
        bit seen;
        exp = model(o, x, y);
        @(negedge clk);
        st[u] = 1'b1; opv[u] = o; av[u] = x; bv[u] = y;
        @(negedge clk);
        st[u] = 1'b0;
        if (scramble) begin
            av[u]  = $urandom;
            bv[u]  = $urandom;
            opv[u] = 3'($urandom_range(7));
        end
        bc = 0; n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            if (dn[u]) seen = 1'b1;
            else begin
                if (bsy[u]) bc++;
                n++;
                @(negedge clk);
            end
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " busy_cycles"}, 32'(bc), 32'(32 / slice_of(u)));
        check({tag, " result"}, res[u], exp);
        check({tag, " zero"}, 32'(zr[u]), 32'(exp == 32'd0));
        @(negedge clk);
        check({tag, " done_one_cycle"}, 32'(dn[u]), 32'd0);
        repeat (2) @(negedge clk);
        check({tag, " result_held"}, res[u], exp);
    endtask

    initial begin
        int dcount;
        int bcount;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  ro;
        bit bad_res;

        for (int u = 0; u < 4; u++) begin
            st[u] = 1'b0; opv[u] = 3'd0; av[u] = 32'd0; bv[u] = 32'd0;
        end

        // Reset
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset result", res[0], 32'd0);
        check("reset zero", 32'(zr[0]), 32'd1);
        check("reset busy", 32'(bsy[0]), 32'd0);
        check("reset done", 32'(dn[0]), 32'd0);

        // Directed operations
        do_op(0, 3'd0, 32'h0000_FFFF, 32'h1234_5678, 1'b0, "not");
        do_op(0, 3'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, "xor_self");
        do_op(0, 3'd6, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, "xnor_self");
        do_op(0, 3'd1, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1, "and_scramble");
        check("and literal", res[0], 32'h00F0_1234);

        // Randomized operations against the whole-word model
        for (int i = 0; i < 10; i++) begin
            do_op(0, 3'($urandom_range(7)), $urandom, $urandom, (i % 2) == 1,
                  $sformatf("rand%0d", i));
        end

        // start held high: one accept per NSLICE+2 cycles, no queuing
        ra = $urandom; rb = $urandom; ro = 3'd2;
        @(negedge clk);
        st[0] = 1'b1; opv[0] = ro; av[0] = ra; bv[0] = rb;
        @(negedge clk);
        dcount = 0; bcount = 0; bad_res = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (dn[0]) begin
                dcount++;
                if (res[0] !== model(ro, ra, rb)) bad_res = 1'b1;
            end
            if (bsy[0]) bcount++;
            if (i == 17) st[0] = 1'b0;
            @(negedge clk);
        end
        check("held done_count", 32'(dcount), 32'd3);
        check("held busy_cycles", 32'(bcount), 32'd12);
        check("held result_ok", 32'(bad_res), 32'd0);
        repeat (8) begin
            if (dn[0] || bsy[0]) dcount++;
            @(negedge clk);
        end
        check("held no_queue", 32'(dcount), 32'd3);

        // Reset in the 2nd busy cycle aborts the operation
        @(negedge clk);
        st[0] = 1'b1; opv[0] = 3'd7; av[0] = 32'hFFFF_FFFF; bv[0] = 32'd0;
        @(negedge clk);
        st[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", 32'(bsy[0]), 32'd0);
        check("abort result", res[0], 32'd0);
        check("abort zero", 32'(zr[0]), 32'd1);
        dcount = 0;
        repeat (8) begin
            if (dn[0]) dcount++;
            @(negedge clk);
        end
        check("abort no_done", 32'(dcount), 32'd0);
        do_op(0, 3'd4, 32'hFF00_FF00, 32'hF0F0_F0F0, 1'b0, "after_abort");

        // Slice-width sweep: NOR of zeros gives all ones
        do_op(1, 3'd5, 32'd0, 32'd0, 1'b0, "sweep32");
        do_op(2, 3'd5, 32'd0, 32'd0, 1'b0, "sweep16");
        do_op(3, 3'd5, 32'd0, 32'd0, 1'b0, "sweep4");
        do_op(3, 3'($urandom_range(7)), $urandom, $urandom, 1'b1, "sweep4_rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
